// File: rtl/mac_if.sv
// Handshake and data bundle between the ControlMux sequencer and the MAC accumulator.
// The selections, term tags and operand buses go in; the published sample and its flags come out.
interface mac_if #(
  parameter int WIDTH = 16
);
  logic               step_en;
  logic [2:0]         sel_const;
  logic [1:0]         sel_fun;
  logic               sel_acum;
  logic               Band_Listo;
  logic [8*WIDTH-1:0] const_bus;
  logic [4*WIDTH-1:0] fun_bus;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic               ovf;

  modport master (
    output step_en, sel_const, sel_fun, sel_acum, Band_Listo, const_bus, fun_bus,
    input  y, y_valid, ovf
  );

  modport slave (
    input  step_en, sel_const, sel_fun, sel_acum, Band_Listo, const_bus, fun_bus,
    output y, y_valid, ovf
  );
endinterface

// File: rtl/mac_acumulador.sv
// Two-stage saturating fixed-point multiply-accumulate: stage 1 scales k*f back to Q format,
// stage 2 loads or accumulates it and publishes the sum on the last term of a sequence.
module mac_acumulador #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input logic clk,
  input logic reset,
  mac_if.slave bus
);

  localparam logic signed [WIDTH-1:0]   MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Returns {saturated, value}; the shift floors toward -inf.
  function automatic logic [WIDTH:0] sat_prod(input logic signed [2*WIDTH-1:0] p);
    logic signed [2*WIDTH-1:0] sh;
    sh = p >>> FRAC;
    if (sh > PMAX)      return {1'b1, MAXV};
    else if (sh < PMIN) return {1'b1, MINV};
    else                return {1'b0, sh[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH:0] sat_add(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MINV : MAXV)};
    else                        return {1'b0, s[WIDTH-1:0]};
  endfunction

  logic signed [WIDTH-1:0]   k_arr [8];
  logic signed [WIDTH-1:0]   f_arr [4];
  logic signed [WIDTH-1:0]   k_sel;
  logic signed [WIDTH-1:0]   f_sel;
  logic signed [2*WIDTH-1:0] prod_full;
  logic        [WIDTH:0]     prod_sat;

  for (genvar i = 0; i < 8; i++) begin : g_k
    assign k_arr[i] = bus.const_bus[i*WIDTH +: WIDTH];
  end
  for (genvar j = 0; j < 4; j++) begin : g_f
    assign f_arr[j] = bus.fun_bus[j*WIDTH +: WIDTH];
  end

  assign k_sel     = k_arr[bus.sel_const];
  assign f_sel     = f_arr[bus.sel_fun];
  assign prod_full = k_sel * f_sel;
  assign prod_sat  = sat_prod(prod_full);

  // ---- stage 1: scaled, saturated product ----
  logic signed [WIDTH-1:0] prod_p1;
  logic                    vld_p1;
  logic                    acum_p1;
  logic                    listo_p1;
  logic                    sat_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_p1  <= '0;
      vld_p1   <= 1'b0;
      acum_p1  <= 1'b0;
      listo_p1 <= 1'b0;
      sat_p1   <= 1'b0;
    end else begin
      vld_p1 <= bus.step_en;
      if (bus.step_en) begin
        prod_p1  <= prod_sat[WIDTH-1:0];
        acum_p1  <= bus.sel_acum;
        listo_p1 <= bus.Band_Listo;
        sat_p1   <= prod_sat[WIDTH];
      end
    end
  end

  // ---- stage 2: accumulate and publish ----
  logic signed [WIDTH-1:0] acc_p2;
  logic signed [WIDTH-1:0] y_p2;
  logic                    vld_p2;
  logic                    ovf_p2;
  logic        [WIDTH:0]   add_res;
  logic signed [WIDTH-1:0] acc_next;
  logic                    add_sat;

  assign add_res  = sat_add(acc_p2, prod_p1);
  assign acc_next = acum_p1 ? add_res[WIDTH-1:0] : prod_p1;
  assign add_sat  = acum_p1 & add_res[WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_p2 <= '0;
      y_p2   <= '0;
      vld_p2 <= 1'b0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1 & listo_p1;
      if (vld_p1) begin
        acc_p2 <= acc_next;
        // A load term starts a new sequence, so the sticky flag restarts from this term.
        ovf_p2 <= acum_p1 ? (ovf_p2 | sat_p1 | add_sat) : sat_p1;
        if (listo_p1) y_p2 <= acc_next;
      end
    end
  end

  assign bus.y       = y_p2;
  assign bus.y_valid = vld_p2;
  assign bus.ovf     = ovf_p2;

endmodule
